// File: rtl/inst_rom_arb_pkg.sv
`include "defines.sv"
`default_nettype none
// ============================================================================
// Module      : inst_rom_arb_pkg
// Description : Shared types, constants and the address legality check for
//               the two-port instruction-ROM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_rom_arb_pkg;

    localparam int         c_NUM_PORTS = 2;

    // last_grant encoding: names the port that won the most recent grant.
    localparam logic [0:0] c_LG_PORT0  = 1'b0;
    localparam logic [0:0] c_LG_PORT1  = 1'b1;
    // Reset points at port 1 so port 0 wins the first contention.
    localparam logic [0:0] c_LG_RESET  = c_LG_PORT1;

    typedef struct packed {
        logic             ack;
        logic             err;
        logic [`InstBus]  rdata;
    } port_rsp_t;

    localparam port_rsp_t c_RSP_RESET = '{ack: 1'b0, err: 1'b0, rdata: `ZeroWord};

    // An access is illegal when it is not word aligned or when any bit above
    // the ROM word index is set.
    function automatic logic addr_is_bad(input logic [`InstAddrBus] addr,
                                         input int                  words_log2);
        logic [`InstAddrBus] upper;
        upper = addr >> (words_log2 + 2);
        return (addr[1:0] != 2'b00) || (upper != `ZeroWord);
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_rom_arb_if.sv
`include "defines.sv"
`default_nettype none
// ============================================================================
// Module      : inst_rom_arb_if
// Description : Requester ports (m0 = fetch, m1 = data-side code read) and
//               ROM side of the instruction-ROM arbiter.
//               slave  : arbiter view
//               master : requesters + ROM view
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_rom_arb_if;
    logic                 m0_req;
    logic [`InstAddrBus]  m0_addr;
    logic                 m0_ack;
    logic [`InstBus]      m0_rdata;
    logic                 m0_err;

    logic                 m1_req;
    logic [`InstAddrBus]  m1_addr;
    logic                 m1_ack;
    logic [`InstBus]      m1_rdata;
    logic                 m1_err;

    logic                 rom_ce;
    logic [`InstAddrBus]  rom_addr;
    logic [`InstBus]      rom_inst;

    modport slave (
        input  m0_req, m0_addr, m1_req, m1_addr, rom_inst,
        output m0_ack, m0_rdata, m0_err, m1_ack, m1_rdata, m1_err, rom_ce, rom_addr
    );

    modport master (
        output m0_req, m0_addr, m1_req, m1_addr, rom_inst,
        input  m0_ack, m0_rdata, m0_err, m1_ack, m1_rdata, m1_err, rom_ce, rom_addr
    );
endinterface
`default_nettype wire

// File: rtl/defines.sv
`ifndef INST_ROM_ARB_SHARED_DEFINES
`define INST_ROM_ARB_SHARED_DEFINES
// ============================================================================
// Module      : (shared defines)
// Description : Bus widths, chip-enable levels and ROM sizing shared by the
//               instruction-ROM path.
// Revision    : 1.0 - initial release
// ============================================================================
`define ChipEnable      1'b1
`define ChipDisable     1'b0
`define ZeroWord        32'h00000000
`define InstAddrBus     31:0
`define InstBus         31:0
`define InstMemNumLog2  17
`endif

// File: rtl/inst_rom_arb_rr_arb2.sv
`include "defines.sv"
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way combinational pick, round-robin or fixed priority.
//   eligible_i   [1:0] ports requesting service this cycle
//   last_grant_i       port that won the previous grant
//   grant_o      [1:0] one-hot winner (zero when nobody is eligible)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import inst_rom_arb_pkg::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  wire logic [1:0] eligible_i,
    input  wire logic       last_grant_i,
    output logic      [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (eligible_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11: begin
                // Contention: port 0 wins if fixed priority, otherwise the
                // port that did not win last time.
                if ((FIXED_PRI != 0) || (last_grant_i == c_LG_PORT1)) begin
                    grant_o = 2'b01;
                end else begin
                    grant_o = 2'b10;
                end
            end
            default: grant_o = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/inst_rom_arb.sv
`include "defines.sv"
`default_nettype none
// ============================================================================
// Module      : inst_rom_arb
// Description : Shares one combinational instruction ROM between two read
//               ports. One grant per cycle; the granted port is acked one
//               cycle later with the captured word or an error.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : m0_*/m1_* request/response ports and rom_ce/rom_addr/rom_inst
// Revision    : 1.0 - initial release
// ============================================================================
module inst_rom_arb
    import inst_rom_arb_pkg::*;
#(
    parameter int FIXED_PRI      = 0,
    parameter int ROM_WORDS_LOG2 = `InstMemNumLog2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    inst_rom_arb_if.slave bus
);

    logic [1:0]           w_req;
    logic [`InstAddrBus]  w_addr [c_NUM_PORTS];
    logic [1:0]           w_bad;
    logic [1:0]           w_eligible;
    logic [1:0]           w_grant;

    port_rsp_t            rsp_q [c_NUM_PORTS];
    port_rsp_t            rsp_d [c_NUM_PORTS];
    logic                 last_grant_q;
    logic                 last_grant_d;

    assign w_req     = {bus.m1_req, bus.m0_req};
    assign w_addr[0] = bus.m0_addr;
    assign w_addr[1] = bus.m1_addr;

    // A port whose ack is high this cycle is still holding the request it was
    // just served for, so it is masked. Reset masks everyone so the ROM is
    // idle and no grant is taken while rst is high.
    always_comb begin
        for (int p = 0; p < c_NUM_PORTS; p++) begin
            w_bad[p]      = addr_is_bad(w_addr[p], ROM_WORDS_LOG2);
            w_eligible[p] = w_req[p] & ~rsp_q[p].ack & ~rst;
        end
    end

    rr_arb2 #(
        .FIXED_PRI    (FIXED_PRI)
    ) u_pick (
        .eligible_i   (w_eligible),
        .last_grant_i (last_grant_q),
        .grant_o      (w_grant)
    );

    always_comb begin
        bus.rom_ce   = `ChipDisable;
        bus.rom_addr = `ZeroWord;
        if (w_grant[0]) begin
            bus.rom_ce   = `ChipEnable;
            bus.rom_addr = w_addr[0];
        end else if (w_grant[1]) begin
            bus.rom_ce   = `ChipEnable;
            bus.rom_addr = w_addr[1];
        end
    end

    // Error accesses still ack and still count as a grant for round-robin;
    // rdata/err otherwise hold until the port's next grant.
    always_comb begin
        last_grant_d = last_grant_q;
        for (int p = 0; p < c_NUM_PORTS; p++) begin
            rsp_d[p]     = rsp_q[p];
            rsp_d[p].ack = w_grant[p];
            if (w_grant[p]) begin
                rsp_d[p].err   = w_bad[p];
                rsp_d[p].rdata = w_bad[p] ? `ZeroWord : bus.rom_inst;
            end
        end
        if (w_grant[0]) begin
            last_grant_d = c_LG_PORT0;
        end else if (w_grant[1]) begin
            last_grant_d = c_LG_PORT1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < c_NUM_PORTS; p++) begin
                rsp_q[p] <= c_RSP_RESET;
            end
            last_grant_q <= c_LG_RESET;
        end else begin
            for (int p = 0; p < c_NUM_PORTS; p++) begin
                rsp_q[p] <= rsp_d[p];
            end
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.m0_ack   = rsp_q[0].ack;
    assign bus.m0_err   = rsp_q[0].err;
    assign bus.m0_rdata = rsp_q[0].rdata;
    assign bus.m1_ack   = rsp_q[1].ack;
    assign bus.m1_err   = rsp_q[1].err;
    assign bus.m1_rdata = rsp_q[1].rdata;

endmodule
`default_nettype wire

// File: doc/inst_rom_arb.md
INST_ROM_ARB -- requirements
Module: inst_rom_arb

Interface
REQ-001 Parameter FIXED_PRI, default 0, 0 = round-robin arbitration, 1 = port 0 always wins.
REQ-002 Parameter ROM_WORDS_LOG2, default `InstMemNumLog2, the ROM word-index width used by the bound check.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 m0_req  in  1  port 0 (instruction fetch) read request, held until m0_ack.
REQ-006 m0_addr  in  32 (`InstAddrBus)  port 0 byte address, stable while m0_req is high.
REQ-007 m0_ack  out  1  one-cycle pulse; m0_rdata and m0_err are valid.
REQ-008 m0_rdata  out  32 (`InstBus)  port 0 read word.
REQ-009 m0_err  out  1  port 0 access was misaligned or out of range.
REQ-010 m1_req, m1_addr, m1_ack, m1_rdata, m1_err  same as port 0, for port 1 (data-side code-space read).
REQ-011 rom_ce  out  1  ROM chip enable (`ChipEnable / `ChipDisable).
REQ-012 rom_addr  out  32  byte address driven to the ROM.
REQ-013 rom_inst  in  32  combinational ROM read data.

Function
REQ-014 Each cycle, a port is eligible when its req is high and its ack is low in that same cycle; this prevents double service of a held request.
REQ-015 With no eligible port: rom_ce = `ChipDisable, rom_addr = `ZeroWord, and no grant.
REQ-016 With one eligible port, that port is granted.
REQ-017 With both ports eligible and FIXED_PRI = 0: the port not named in last_grant wins.
REQ-018 With both ports eligible and FIXED_PRI = 1: port 0 wins.
REQ-019 last_grant updates only on a grant cycle.
REQ-020 Grant cycle: rom_ce = `ChipEnable and rom_addr = the granted address, both combinational.
REQ-021 In the cycle after a grant, the granted port's ack = 1 and its rdata = the rom_inst value captured at the grant edge; latency is exactly 1 cycle.
REQ-022 The other port's ack = 0 in that cycle.
REQ-023 An access is an error if addr[1:0] != 0 or addr[31:ROM_WORDS_LOG2+2] != 0.
REQ-024 On an error access: err = 1, rdata = `ZeroWord, the ack is still given, and the error access counts as a grant for round-robin.
REQ-025 rdata and err hold their values until that port's next ack; ack is high for exactly one cycle per grant.
REQ-026 Throughput: one grant per cycle maximum; alternating ports sustain one grant per cycle; a lone port sustains one per 2 cycles.
REQ-027 Worst-case wait for an eligible port in round-robin mode is 1 grant.
REQ-028 A req dropped before its ack is a protocol violation; behaviour is undefined, and no state other than last_grant is corrupted.

Reset
REQ-029 While rst = 1, asynchronously: m0_ack = m1_ack = 0, m0_err = m1_err = 0, m0_rdata = m1_rdata = `ZeroWord, last_grant = 1 (port 0 wins first), rom_ce = `ChipDisable.
REQ-030 Reset asserted in a grant cycle discards that grant; no ack follows reset release.
REQ-031 Arbitration resumes on the first rising clk edge after rst deasserts.

Structure
REQ-032 `ChipEnable, `ChipDisable, `ZeroWord, `InstAddrBus, `InstBus and `InstMemNumLog2 come from the shared defines.v; no local redefinition.
REQ-033 The two-way round-robin/fixed-priority pick (inputs: eligible[1:0], last_grant, FIXED_PRI; output: grant[1:0]) is one combinational sub-module, rr_arb2.
REQ-034 The per-port response registers and the bound/alignment check sit in inst_rom_arb.

Verification
REQ-035 Port 0 only: m0_addr = 0x00000008 held, ROM word 2 = 0x34011100 -> rom_ce high in cycle 0, m0_ack in cycle 1 with rdata 0x34011100, no grant in cycle 1, next grant in cycle 2.
REQ-036 Both ports request every cycle: m0 at 0x0, m1 at 0x4 -> grants alternate 0,1,0,1 starting with port 0; one ack per cycle from cycle 1; no port waits more than 1 grant.
REQ-037 FIXED_PRI = 1, both request continuously -> port 0 acked cycles 1,3,5; port 1 granted only in port 0's masked cycles (acked cycles 2,4).
REQ-038 m1_addr = 0x00000006 -> m1_ack with m1_err = 1 and m1_rdata = 0x00000000.
REQ-039 Out-of-range access: m1_addr = 1 << (ROM_WORDS_LOG2+2) -> m1_err = 1.
REQ-040 rst pulsed asynchronously mid-cycle during a port 0 grant -> all outputs zero immediately; no m0_ack after release; the first post-reset contention grants port 0.
